handshake_writer: RTL and testbench
===================================

Name: handshake_writer

Overview:
Transmit (initiator) end of the two-way four-phase req/ack handshake. Accepts words from a local valid/ready source into a small FIFO. Each word is presented on a[] with req asserted. The block holds req and a[] until ack rises, then drops req and waits for ack to fall before the next transfer. Sits in front of the handshake receiver on the same clk/reset.

Parameters:
DW, 8, data width of din and a
DEPTH, 4, FIFO entries (power of two, >=2); the in-flight word counts as an occupied entry
TO_CYCLES, 255, wait-state timeout threshold in cycles (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
din  input  DW  local write data
din_valid  input  1  din is valid
din_ready  output  1  FIFO can accept; a write occurs when din_valid && din_ready at a rising edge
a  output  DW  handshake data, registered
req  output  1  handshake request, registered
ack  input  1  handshake acknowledge from receiver, same clock domain, sampled directly
level  output  $clog2(DEPTH)+1  FIFO occupancy, including the in-flight word
busy  output  1  FSM not IDLE or FIFO non-empty
timeout_err  output  1  sticky error (optional feature)
err_clr  input  1  clears timeout_err (optional feature)

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - req=0, a=0, level=0, busy=0, timeout_err=0, FSM=IDLE.
  - din_ready=1 once reset is deasserted.
  - Reset mid-transfer abandons the word; req falls immediately (asynchronously).
- FIFO:
  - din_ready = (level != DEPTH); registered count only, no same-cycle pass-through.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT_HI, WAIT_LO.
  - IDLE: req=0. When the FIFO is non-empty and ack==0, load a<=head and req<=1, and go to WAIT_HI. If ack==1 in IDLE (stale), stay in IDLE.
  - WAIT_HI: req=1, a stable. On ack==1, set req<=0, pop the FIFO head, and go to WAIT_LO.
  - WAIT_LO: req=0, a unchanged. On ack==0, go to IDLE.
- Latency:
  - Word accepted at edge E0 into an empty FIFO with the FSM in IDLE and ack low: req=1 and a=word after edge E1.
  - Minimum transfer period: 4 cycles plus receiver response time.
  - Back-to-back words: the next req rises on the edge after ack is seen low in WAIT_LO (via IDLE).
- Data stability: a[] changes only on the IDLE->WAIT_HI load. a[] is constant whenever req=1 and through WAIT_LO.
- ack rules:
  - ack is ignored unless its level matches the awaited one.
  - A glitch-free, level-based protocol is required of the receiver.
- level counts the in-flight word until the pop at the ack-high edge. DEPTH words can therefore be pending, including the in-flight one.

Optional Feature:
HANDSHAKE_WRITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_HI or WAIT_LO and increments each cycle in that state.
  - If the awaited ack level is not seen by the TO_CYCLES-th rising edge after entry, timeout_err<=1 (sticky).
  - The FSM keeps waiting; req and a are unchanged.
  - err_clr=1 clears the flag at the next edge. A simultaneous new timeout wins (flag stays 1).
- Undefined: counter is absent, timeout_err is tied 0, and err_clr is ignored.

Decomposition:
- Shared package hs_pkg holds:
  - state localparams ST_IDLE, ST_WAIT_HI, ST_WAIT_LO
  - default DW
  - shared with the receiver side.
- One natural sub-module: hs_fifo (DEPTH x DW synchronous FIFO with push/pop/level/full/empty).
- The FSM and the timeout logic stay in handshake_writer.

Test Plan:
1. Single word: push 0xA5 at E0 into an idle block, paired with the receiver -> req=1, a=0xA5 after E1; req falls the cycle after ack rises; the receiver captures 0xA5; busy returns to 0 after ack falls.
2. Burst: push 0x11,0x22,0x33,0x44 on consecutive cycles with the receiver stalled (ack held 0) -> level=4, din_ready=0; a fifth push of 0x55 is rejected. After ack is released, the receiver gets 0x11..0x44 in order and din_ready re-asserts after the first pop.
3. Stale ack: ack forced 1 while IDLE with 0x3C queued -> req stays 0; ack dropped -> req=1, a=0x3C on the next edge.
4. Reset mid-transfer: assert reset while in WAIT_HI with a=0x7E -> req=0, a=0, level=0 immediately; after release with no pushes, req stays 0.
5. Timeout (macro defined, TO_CYCLES=16): push 0x99, ack tied 0 -> timeout_err=1 on the 16th edge after req rise, req remains 1. Pulse err_clr -> flag=0, then re-sets after 16 more cycles.
6. Timeout build off (macro undefined): same stimulus as scenario 5 -> timeout_err stays 0 throughout.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared definitions for both ends of the four-phase req/ack handshake:
// FSM state encoding, default data width and the "awaited ack level" helper.
package hs_pkg;

  localparam int HS_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_WAIT_LO = 2'd2
  } hs_state_t;

  // True when ack sits at the level the given wait state is looking for.
  function automatic logic ack_awaited(input hs_state_t st, input logic ack);
    logic hit;
    case (st)
      ST_WAIT_HI: hit = ack;
      ST_WAIT_LO: hit = ~ack;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/handshake_writer_if.sv
// Local valid/ready write port plus the req/ack/data handshake of the writer.
// master = the writer itself, slave = the local source and the receiver.
interface handshake_writer_if
  import hs_pkg::*;
#(
  parameter int DW = HS_DW
);

  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] a;
  logic          req;
  logic          ack;

  modport master (
    input  din,
    input  din_valid,
    input  ack,
    output din_ready,
    output a,
    output req
  );

  modport slave (
    output din,
    output din_valid,
    output ack,
    input  din_ready,
    input  a,
    input  req
  );

endinterface

// File: rtl/hs_fifo.sv
// DEPTH x DW synchronous FIFO; pushes while full and pops while empty are
// ignored, and level is the registered occupancy.
module hs_fifo
  import hs_pkg::*;
#(
  parameter int DW    = HS_DW,
  parameter int DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == LW'(DEPTH));
  assign empty     = (count_r == {LW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign level     = count_r;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/handshake_writer.sv
// Initiator end of the four-phase req/ack handshake, fed from a small FIFO.
// Optional wait-state timeout: define HANDSHAKE_WRITER_TIMEOUT_EN.
module handshake_writer
  import hs_pkg::*;
#(
  parameter int DW        = HS_DW,
  parameter int DEPTH     = 4,
  parameter int TO_CYCLES = 255
)(
  input  logic                   clk,
  input  logic                   reset,
  handshake_writer_if.master     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  hs_state_t     state_r;
  logic [DW-1:0] a_r;
  logic          req_r;
  logic [DW-1:0] head_s;
  logic          full_s;
  logic          empty_s;
  logic          pop_s;

  // The in-flight word stays counted until ack is seen high.
  assign pop_s = (state_r == ST_WAIT_HI) & bus.ack;

  hs_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.din_valid),
    .wdata (bus.din),
    .pop   (pop_s),
    .head  (head_s),
    .level (level),
    .full  (full_s),
    .empty (empty_s)
  );

  assign bus.din_ready = ~full_s;
  assign bus.a         = a_r;
  assign bus.req       = req_r;
  assign busy          = (state_r != ST_IDLE) | ~empty_s;

  // Handshake FSM; a stale high ack in IDLE holds off the next request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      a_r     <= {DW{1'b0}};
      req_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s && !bus.ack) begin
            a_r     <= head_s;
            req_r   <= 1'b1;
            state_r <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (ack_awaited(state_r, bus.ack)) begin
            req_r   <= 1'b0;
            state_r <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (ack_awaited(state_r, bus.ack)) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef HANDSHAKE_WRITER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);

  logic [TW-1:0] to_cnt_r;
  logic          to_err_r;
  logic          waiting_s;
  logic          to_fire_s;

  // Staying in a wait state this cycle; any other cycle restarts the count,
  // which is what clears it on entry to WAIT_HI / WAIT_LO.
  always_comb begin
    waiting_s = 1'b0;
    to_fire_s = 1'b0;
    if ((state_r == ST_WAIT_HI) || (state_r == ST_WAIT_LO)) begin
      waiting_s = ~ack_awaited(state_r, bus.ack);
      to_fire_s = waiting_s & (to_cnt_r == TW'(TO_CYCLES - 1));
    end else begin
      waiting_s = 1'b0;
      to_fire_s = 1'b0;
    end
  end

  // Wait-state cycle counter; restarts after firing so a cleared flag re-arms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_r <= {TW{1'b0}};
    end else if (!waiting_s || to_fire_s) begin
      to_cnt_r <= {TW{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // Sticky error flag; a new timeout outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_err_r <= 1'b0;
    end else if (to_fire_s) begin
      to_err_r <= 1'b1;
    end else if (err_clr) begin
      to_err_r <= 1'b0;
    end else begin
      to_err_r <= to_err_r;
    end
  end

  assign timeout_err = to_err_r;
`else
  localparam int unused_to_cycles = TO_CYCLES;
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_writer.sv
// Self-checking bench for handshake_writer: cycle tables, reset/timeout
// sequences, and randomized traffic against a FIFO-order reference model.
module tb_handshake_writer;
  import hs_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam int LW    = 3;
`ifdef HANDSHAKE_WRITER_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          err_clr = 1'b0;
  logic [LW-1:0] level;
  logic          busy;
  logic          timeout_err;

  handshake_writer_if #(.DW(DW)) bus();

  handshake_writer #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .TO_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .level       (level),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            lvl_m   = 0;
  logic [DW-1:0] exp_q[$];
  int            rx_dly  = 0;
  logic          prev_req = 1'b0;
  logic [DW-1:0] a_hold  = '0;

  typedef struct {
    logic          dv;
    logic [DW-1:0] din;
    logic          ack;
    logic          exp_req;
    logic [DW-1:0] exp_a;
    logic [LW-1:0] exp_lvl;
    logic          exp_rdy;
    logic          exp_busy;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: update the level/order model from pre-edge handshakes.
  task automatic tick();
    logic          pu;
    logic          po;
    logic [DW-1:0] d;
    pu = bus.din_valid && bus.din_ready;
    po = bus.req && bus.ack;
    d  = bus.din;
    @(posedge clk);
    #1;
    if (pu) begin
      lvl_m++;
      exp_q.push_back(d);
    end
    if (po) begin
      lvl_m--;
    end
  endtask

  task automatic do_reset();
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.ack       = 1'b0;
    err_clr       = 1'b0;
    reset         = 1'b1;
    #12;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    lvl_m    = 0;
    prev_req = 1'b0;
    rx_dly   = 0;
    exp_q.delete();
  endtask

  // Receiver model: level-based ack with random response delays.
  task automatic respond();
    logic [DW-1:0] e;
    if (bus.req && !bus.ack) begin
      if (rx_dly == 0) begin
        check("rx underflow", 32'(exp_q.size() != 0), 32'(1'b1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rx data", 32'(bus.a), 32'(e));
        end
        bus.ack = 1'b1;
        rx_dly  = $urandom_range(0, 2);
      end else begin
        rx_dly--;
      end
    end else if (!bus.req && bus.ack) begin
      if (rx_dly == 0) begin
        bus.ack = 1'b0;
        rx_dly  = $urandom_range(0, 3);
      end else begin
        rx_dly--;
      end
    end
  endtask

  task automatic rand_checks();
    check("level", 32'(level), 32'(lvl_m));
    check("din_ready", 32'(bus.din_ready), 32'(lvl_m != DEPTH));
    if (bus.req && prev_req) begin
      check("a stable", 32'(bus.a), 32'(a_hold));
    end
    if (bus.req && !prev_req) begin
      a_hold = bus.a;
    end
    prev_req = bus.req;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single word, stale ack, then burst with a rejected fifth push.
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 3'd1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 3'd1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 3'd1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 3'd0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 3'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h3C, 3'd1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 3'd2, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 3'd3, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h11, 3'd4, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h11, 3'd4, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 3'd3, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 3'd3, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 3'd3, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 3'd3, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 3'd2, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 3'd2, 1'b1, 1'b1};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 3'd2, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 3'd1, 1'b1, 1'b1};
    tbl[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 3'd1, 1'b1, 1'b1};
    tbl[24] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 3'd1, 1'b1, 1'b1};
    tbl[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 3'd0, 1'b1, 1'b1};
    tbl[26] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h44, 3'd0, 1'b1, 1'b0};

    do_reset();
    check("rst req", 32'(bus.req), 32'(1'b0));
    check("rst a", 32'(bus.a), 32'(8'h00));
    check("rst level", 32'(level), 32'(3'd0));
    check("rst busy", 32'(busy), 32'(1'b0));
    check("rst timeout_err", 32'(timeout_err), 32'(1'b0));
    check("rst din_ready", 32'(bus.din_ready), 32'(1'b1));

    for (int i = 0; i < 27; i++) begin
      bus.din_valid = tbl[i].dv;
      bus.din       = tbl[i].din;
      bus.ack       = tbl[i].ack;
      tick();
      check($sformatf("row%0d req", i), 32'(bus.req), 32'(tbl[i].exp_req));
      check($sformatf("row%0d a", i), 32'(bus.a), 32'(tbl[i].exp_a));
      check($sformatf("row%0d level", i), 32'(level), 32'(tbl[i].exp_lvl));
      check($sformatf("row%0d din_ready", i), 32'(bus.din_ready), 32'(tbl[i].exp_rdy));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      check($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'(1'b0));
    end

    // Reset while waiting for ack high.
    do_reset();
    bus.din = 8'h7E;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    tick();
    check("mid req before", 32'(bus.req), 32'(1'b1));
    check("mid a before", 32'(bus.a), 32'(8'h7E));
    #3;
    reset = 1'b1;
    #1;
    check("mid async req", 32'(bus.req), 32'(1'b0));
    check("mid async a", 32'(bus.a), 32'(8'h00));
    check("mid async level", 32'(level), 32'(3'd0));
    check("mid async busy", 32'(busy), 32'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    lvl_m = 0;
    exp_q.delete();
    repeat (4) tick();
    check("post rst req", 32'(bus.req), 32'(1'b0));
    check("post rst level", 32'(level), 32'(3'd0));
    check("post rst din_ready", 32'(bus.din_ready), 32'(1'b1));

    // Timeout: ack held low with one word in flight.
    do_reset();
    bus.din = 8'h99;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    tick();
    check("to req rise", 32'(bus.req), 32'(1'b1));
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 15) check("to edge15", 32'(timeout_err), 32'(1'b0));
    end
    tick();
    check("to edge16", 32'(timeout_err), 32'(EXP_TO));
    check("to req held", 32'(bus.req), 32'(1'b1));
    check("to a held", 32'(bus.a), 32'(8'h99));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to cleared", 32'(timeout_err), 32'(1'b0));
    repeat (14) tick();
    check("to edge31", 32'(timeout_err), 32'(1'b0));
    tick();
    check("to edge32", 32'(timeout_err), 32'(EXP_TO));
    repeat (15) tick();
    check("to sticky", 32'(timeout_err), 32'(EXP_TO));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to fire beats clr", 32'(timeout_err), 32'(EXP_TO));
    check("to req still", 32'(bus.req), 32'(1'b1));

    // Randomized traffic with a responsive receiver.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.din_valid = 1'($urandom_range(0, 1));
      bus.din       = 8'($urandom);
      tick();
      rand_checks();
      respond();
    end
    bus.din_valid = 1'b0;
    begin
      bit done;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        tick();
        rand_checks();
        respond();
        if (lvl_m == 0 && !busy && !bus.ack) done = 1'b1;
      end
      check("drain done", 32'(done), 32'(1'b1));
    end
    check("drain queue", 32'(exp_q.size()), 32'(0));
    check("drain level", 32'(level), 32'(3'd0));
    check("drain busy", 32'(busy), 32'(1'b0));
    check("drain timeout_err", 32'(timeout_err), 32'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
